mem_wb_skid_register: RTL and testbench

- Parametrised MEM/WB pipeline boundary register with a valid/ready elastic handshake.
- Absorbs stalls caused by multi-cycle cache misses without dropping beats, using an optional 2-entry skid buffer.
- Supports synchronous flush and suppresses writes to x0.
- Provides two combinational forwarding lookup ports so EX can bypass from in-flight WB results; also keeps a saturating back-pressure counter for performance debug.

---
 rtl/mem_wb_skid_register_pkg.sv | 17 +
 rtl/mem_wb_skid_register_fwd_match.sv | 37 +++
 rtl/mem_wb_skid_register.sv | 162 ++++++++++++++++
 tb/tb_mem_wb_skid_register.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_skid_register_pkg.sv
// Shared MEM/WB pipeline definitions: default widths, the x0 register index
// and the write-back beat layout carried across the boundary.
package mem_wb_skid_register_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Register index of the hard-wired zero register; writes to it are dropped.
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]     data;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic                      we;
    } wb_beat_t;

endpackage

// File: rtl/mem_wb_skid_register_fwd_match.sv
// Forwarding lookup against the two held beats; the skid entry is younger
// than the main entry, so it wins when both match.
module wb_fwd_match
    import mem_wb_skid_register_pkg::*;
#(
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  REG_ADDR_W = REG_ADDR_W_DEF,
    parameter type beat_t     = wb_beat_t
) (
    input  logic                  m_valid,
    input  beat_t                 m,
    input  logic                  s_valid,
    input  beat_t                 s,
    input  logic [REG_ADDR_W-1:0] rs,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic rs_live;
    logic hit_m;
    logic hit_s;

    assign rs_live = (rs != REG_ADDR_W'(REG_ZERO));
    assign hit_m   = rs_live && m_valid && m.we && (m.rd == rs);
    assign hit_s   = rs_live && s_valid && s.we && (s.rd == rs);

    always_comb begin
        hit  = hit_s || hit_m;
        data = '0;
        if (hit_s) begin
            data = s.data;
        end else if (hit_m) begin
            data = m.data;
        end
    end

endmodule

// File: rtl/mem_wb_skid_register.sv
// MEM/WB boundary register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush, x0 write suppression, forwarding and stall counter.
module mem_wb_skid_register
    import mem_wb_skid_register_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int SKID_EN     = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      wb_data_in,
    input  logic [REG_ADDR_W-1:0]  rd_in,
    input  logic                   is_write_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      wb_data_out,
    output logic [REG_ADDR_W-1:0]  rd_out,
    output logic                   is_write_out,
    input  logic [REG_ADDR_W-1:0]  fwd_rs_a,
    input  logic [REG_ADDR_W-1:0]  fwd_rs_b,
    output logic                   fwd_hit_a,
    output logic                   fwd_hit_b,
    output logic [DATA_W-1:0]      fwd_data_a,
    output logic [DATA_W-1:0]      fwd_data_b,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } beat_t;

    beat_t m_q, m_d;
    beat_t s_q, s_d;
    logic  m_valid_q, m_valid_d;
    logic  s_valid_q, s_valid_d;
    beat_t in_beat;
    logic  accept;
    logic  drain;
    logic  stall;

    assign in_beat = '{
        data: wb_data_in,
        rd:   rd_in,
        we:   is_write_in && (rd_in != REG_ADDR_W'(REG_ZERO))
    };

    // With the skid entry, ready depends only on state so it can be registered
    // upstream; without it, ready must look through to out_ready.
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign in_ready = !s_valid_q;
        end else begin : g_single_ready
            assign in_ready = !m_valid_q || out_ready;
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign drain  = m_valid_q && out_ready;
    assign stall  = m_valid_q && !out_ready;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path
        // through the branches below leaves one unassigned and infers a latch.
        m_d       = m_q;
        m_valid_d = m_valid_q;
        s_d       = s_q;
        s_valid_d = s_valid_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            // in_ready is low while S is full, so only a drain can happen here.
            if (drain) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q || drain) begin
                m_d       = in_beat;
                m_valid_d = 1'b1;
            end else if (SKID_EN != 0) begin
                s_d       = in_beat;
                s_valid_d = 1'b1;
            end
        end else if (drain) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the payload registers are reset as well because wb_data_out
            // and rd_out are required to read zero straight out of reset.
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values computed in always_comb.
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    // Saturating counter: flush does not clear it, only reset does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign out_valid    = m_valid_q;
    assign wb_data_out  = m_q.data;
    assign rd_out       = m_q.rd;
    assign is_write_out = m_valid_q && m_q.we;

    wb_fwd_match #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .beat_t     (beat_t)
    ) u_fwd_a (
        .m_valid (m_valid_q),
        .m       (m_q),
        .s_valid (s_valid_q),
        .s       (s_q),
        .rs      (fwd_rs_a),
        .hit     (fwd_hit_a),
        .data    (fwd_data_a)
    );

    wb_fwd_match #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .beat_t     (beat_t)
    ) u_fwd_b (
        .m_valid (m_valid_q),
        .m       (m_q),
        .s_valid (s_valid_q),
        .s       (s_q),
        .rs      (fwd_rs_b),
        .hit     (fwd_hit_b),
        .data    (fwd_data_b)
    );

    a_no_overrun: assert property (@(posedge clk) disable iff (reset)
        !(accept && s_valid_q));

endmodule

// File: tb/tb_mem_wb_skid_register.sv
// Directed bench: a per-cycle vector table for streaming, back-pressure and
// x0 cases, then hand sequences for forwarding, flush, single-entry mode and
// counter saturation with mid-stall reset.
module tb_mem_wb_skid_register;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] wb_data_in;
    logic [AW-1:0] rd_in;
    logic          is_write_in;
    logic          out_ready;
    logic [AW-1:0] fwd_rs_a;
    logic [AW-1:0] fwd_rs_b;

    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] wb_data_out;
    logic [AW-1:0] rd_out;
    logic          is_write_out;
    logic          fwd_hit_a;
    logic          fwd_hit_b;
    logic [DW-1:0] fwd_data_a;
    logic [DW-1:0] fwd_data_b;
    logic [CW-1:0] stall_cycles;

    logic          s0_in_ready;
    logic          s0_out_valid;
    logic [DW-1:0] s0_wb_data_out;
    logic [AW-1:0] s0_rd_out;
    logic          s0_is_write_out;
    logic          s0_fwd_hit_a;
    logic          s0_fwd_hit_b;
    logic [DW-1:0] s0_fwd_data_a;
    logic [DW-1:0] s0_fwd_data_b;
    logic [CW-1:0] s0_stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_skid_register #(
        .DATA_W(DW), .REG_ADDR_W(AW), .SKID_EN(1), .STALL_CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_data_in(wb_data_in), .rd_in(rd_in), .is_write_in(is_write_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data_out(wb_data_out), .rd_out(rd_out), .is_write_out(is_write_out),
        .fwd_rs_a(fwd_rs_a), .fwd_rs_b(fwd_rs_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
        .stall_cycles(stall_cycles)
    );

    mem_wb_skid_register #(
        .DATA_W(DW), .REG_ADDR_W(AW), .SKID_EN(0), .STALL_CNT_W(CW)
    ) dut_single (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s0_in_ready),
        .wb_data_in(wb_data_in), .rd_in(rd_in), .is_write_in(is_write_in),
        .out_valid(s0_out_valid), .out_ready(out_ready),
        .wb_data_out(s0_wb_data_out), .rd_out(s0_rd_out), .is_write_out(s0_is_write_out),
        .fwd_rs_a(fwd_rs_a), .fwd_rs_b(fwd_rs_b),
        .fwd_hit_a(s0_fwd_hit_a), .fwd_hit_b(s0_fwd_hit_b),
        .fwd_data_a(s0_fwd_data_a), .fwd_data_b(s0_fwd_data_b),
        .stall_cycles(s0_stall_cycles)
    );

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          we;
        logic          out_ready;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [AW-1:0] e_rd;
        logic          e_we;
        logic          e_in_ready;
        logic [CW-1:0] e_stall;
        logic          e_hit_b;
        logic [DW-1:0] e_fwd_b;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input int iv, input int d, input int rd, input int we,
                                input int ordy, input int ev, input int ed, input int erd,
                                input int ewe, input int eir, input int est,
                                input int ehb, input int efb);
        vec_t v;
        v.in_valid   = 1'(iv);
        v.data       = DW'(d);
        v.rd         = AW'(rd);
        v.we         = 1'(we);
        v.out_ready  = 1'(ordy);
        v.e_valid    = 1'(ev);
        v.e_data     = DW'(ed);
        v.e_rd       = AW'(erd);
        v.e_we       = 1'(ewe);
        v.e_in_ready = 1'(eir);
        v.e_stall    = CW'(est);
        v.e_hit_b    = 1'(ehb);
        v.e_fwd_b    = DW'(efb);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [AW-1:0] rd,
                         input logic we, input logic ordy, input logic fl);
        in_valid    = iv;
        wb_data_in  = d;
        rd_in       = rd;
        is_write_in = we;
        out_ready   = ordy;
        flush       = fl;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        fwd_rs_a = '0;
        fwd_rs_b = 5'd3;
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data", wb_data_out, 0);
        check("rst_rd", rd_out, 0);
        check("rst_is_write", is_write_out, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_single_in_ready", s0_in_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        check("rst_release_in_ready", in_ready, 1);

        // in_valid, data, rd, we, out_ready | valid, data, rd, we, in_ready, stall, hit_b, fwd_b
        vecs[0]  = mk(1, 'h10, 1, 1, 1,  1, 'h10, 1, 1, 1, 0,  0, 0);
        vecs[1]  = mk(1, 'h20, 2, 1, 1,  1, 'h20, 2, 1, 1, 0,  0, 0);
        vecs[2]  = mk(1, 'h30, 3, 1, 1,  1, 'h30, 3, 1, 1, 0,  1, 'h30);
        vecs[3]  = mk(1, 'h40, 4, 1, 1,  1, 'h40, 4, 1, 1, 0,  0, 0);
        vecs[4]  = mk(0, 0,    0, 0, 1,  0, 'h40, 4, 0, 1, 0,  0, 0);
        vecs[5]  = mk(1, 'hAA, 3, 1, 0,  1, 'hAA, 3, 1, 1, 0,  1, 'hAA);
        vecs[6]  = mk(1, 'hBB, 4, 1, 0,  1, 'hAA, 3, 1, 0, 1,  1, 'hAA);
        vecs[7]  = mk(1, 'hCC, 7, 1, 0,  1, 'hAA, 3, 1, 0, 2,  1, 'hAA);
        vecs[8]  = mk(0, 0,    0, 0, 0,  1, 'hAA, 3, 1, 0, 3,  1, 'hAA);
        vecs[9]  = mk(0, 0,    0, 0, 0,  1, 'hAA, 3, 1, 0, 4,  1, 'hAA);
        vecs[10] = mk(0, 0,    0, 0, 0,  1, 'hAA, 3, 1, 0, 5,  1, 'hAA);
        vecs[11] = mk(0, 0,    0, 0, 1,  1, 'hBB, 4, 1, 1, 5,  0, 0);
        vecs[12] = mk(0, 0,    0, 0, 1,  0, 'hBB, 4, 0, 1, 5,  0, 0);
        vecs[13] = mk(1, 'h55, 0, 1, 1,  1, 'h55, 0, 0, 1, 5,  0, 0);
        vecs[14] = mk(1, 'h99, 9, 0, 1,  1, 'h99, 9, 0, 1, 5,  0, 0);
        vecs[15] = mk(0, 0,    0, 0, 1,  0, 'h99, 9, 0, 1, 5,  0, 0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].in_valid, vecs[i].data, vecs[i].rd, vecs[i].we, vecs[i].out_ready, 1'b0);
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_data", i), wb_data_out, vecs[i].e_data);
            check($sformatf("vec%0d_rd", i), rd_out, vecs[i].e_rd);
            check($sformatf("vec%0d_is_write", i), is_write_out, vecs[i].e_we);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
            check($sformatf("vec%0d_stall", i), stall_cycles, vecs[i].e_stall);
            check($sformatf("vec%0d_hit_a_x0", i), fwd_hit_a, 0);
            check($sformatf("vec%0d_fwd_a_x0", i), fwd_data_a, 0);
            check($sformatf("vec%0d_hit_b", i), fwd_hit_b, vecs[i].e_hit_b);
            check($sformatf("vec%0d_fwd_b", i), fwd_data_b, vecs[i].e_fwd_b);
        end

        // Forwarding: M only, then M and S both holding rd=5.
        fwd_rs_a = 5'd5;
        fwd_rs_b = 5'd6;
        drive(1'b1, 32'h111, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check("fwd_m_only_hit", fwd_hit_a, 1);
        check("fwd_m_only_data", fwd_data_a, 32'h111);
        drive(1'b1, 32'h222, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check("fwd_prio_hit_a", fwd_hit_a, 1);
        check("fwd_prio_data_a", fwd_data_a, 32'h222);
        check("fwd_miss_hit_b", fwd_hit_b, 0);
        check("fwd_miss_data_b", fwd_data_b, 0);
        check("fwd_out_holds_m", wb_data_out, 32'h111);
        check("fwd_full_in_ready", in_ready, 0);

        // Flush with M and S full and a beat offered.
        drive(1'b1, 32'h777, 5'd7, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_is_write", is_write_out, 0);
        check("flush_fwd_hit", fwd_hit_a, 0);
        check("flush_keeps_stall", stall_cycles, 7);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check("flush_no_resurrect", out_valid, 0);
        check("flush_data_kept", wb_data_out, 32'h111);

        // Flush discards a beat that is accepted in the same cycle.
        drive(1'b1, 32'h888, 5'd8, 1'b1, 1'b1, 1'b1);
        tick();
        check("flush_accept_valid", out_valid, 0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check("flush_accept_gone", out_valid, 0);
        check("flush_accept_data", wb_data_out, 32'h111);

        // Single-entry variant: combinational ready through out_ready.
        do_reset();
        drive(1'b1, 32'h20, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check("single_out_valid", s0_out_valid, 1);
        check("single_ready_blocked", s0_in_ready, 0);
        drive(1'b1, 32'h30, 5'd3, 1'b1, 1'b1, 1'b0);
        #1;
        check("single_ready_comb", s0_in_ready, 1);
        tick();
        check("single_pass_data", s0_wb_data_out, 32'h30);
        check("single_pass_valid", s0_out_valid, 1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check("single_drained", s0_out_valid, 0);
        check("single_stall", s0_stall_cycles, 0);

        // Saturation of the 4-bit stall counter, then reset mid-stall.
        do_reset();
        drive(1'b1, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (14) tick();
        check("sat_count_14", stall_cycles, 14);
        tick();
        check("sat_count_15", stall_cycles, 15);
        repeat (5) tick();
        check("sat_hold_15", stall_cycles, 15);
        check("sat_out_valid", out_valid, 1);
        check("sat_out_data", wb_data_out, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data", wb_data_out, 0);
        check("midrst_rd", rd_out, 0);
        check("midrst_is_write", is_write_out, 0);
        check("midrst_stall", stall_cycles, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_stall", stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
